// File: rtl/timer_dev.sv
// timer_dev -- memory-mapped down-counting timer with interrupt request.
//
// Registers (word select on addr):
//   0 CTRL   : bit0 EN, bits[2:1] MODE, bit3 IM; upper bits read 0
//   1 PRESET : 32-bit reload value, read/write
//   2 COUNT  : current count, read-only
//   3 reserved, reads 0
//
// Ports:
//   clk  - system clock, all state changes on the rising edge
//   rst  - synchronous active-high reset
//   addr - register word select
//   we   - single-cycle write strobe
//   din  - write data
//   dout - combinational read data for the register selected by addr
//   irq  - interrupt request: IM and (in INT state or pending flag set)
//
// Build option: define TIMER_AUTORELOAD_EN to make MODE=01 reload the
// counter from PRESET after every expiry instead of stopping. Without it,
// MODE=01 behaves like MODE=00 (the MODE bits still read back as written).
module timer_dev (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic        en_reg, en_next;
  logic [1:0]  mode_reg, mode_next;
  logic        im_reg, im_next;
  logic        sticky_reg, sticky_next;
  logic [31:0] preset_reg, preset_next;
  logic [31:0] count_reg, count_next;

  logic wr_ctrl, wr_preset;
  logic reload_mode;
  logic load_count, dec_count, expire_stop;

  assign wr_ctrl   = we && (addr == 2'd0);
  assign wr_preset = we && (addr == 2'd1);

`ifdef TIMER_AUTORELOAD_EN
  assign reload_mode = (mode_reg == 2'b01);
`else
  assign reload_mode = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (en_reg) state_next = LOAD;
      LOAD: state_next = CNT;
      CNT: begin
        if (!en_reg)                state_next = IDLE;
        else if (count_reg == 32'd0) state_next = INT;
      end
      INT: state_next = reload_mode ? LOAD : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs driving the datapath
  always_comb begin
    load_count  = (state_reg == LOAD);
    // Decrement only while enabled and above zero, so COUNT never wraps.
    dec_count   = (state_reg == CNT) && en_reg && (count_reg != 32'd0);
    // One-shot expiry: drop EN and latch the pending flag.
    expire_stop = (state_reg == INT) && !reload_mode;
  end

  // Register-file next values; bus writes are applied last so a CTRL write
  // in the INT cycle overrides the hardware EN clear and pending-flag set.
  always_comb begin
    en_next     = en_reg;
    mode_next   = mode_reg;
    im_next     = im_reg;
    sticky_next = sticky_reg;
    preset_next = preset_reg;
    count_next  = count_reg;

    if (load_count)     count_next = preset_reg;
    else if (dec_count) count_next = count_reg - 32'd1;

    if (expire_stop) begin
      en_next     = 1'b0;
      sticky_next = 1'b1;
    end

    if (wr_ctrl) begin
      en_next   = din[0];
      mode_next = din[2:1];
      im_next   = din[3];
    end
    if (wr_preset) preset_next = din;
    if (wr_ctrl || wr_preset) sticky_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_reg     <= 1'b0;
      mode_reg   <= 2'b00;
      im_reg     <= 1'b0;
      sticky_reg <= 1'b0;
      preset_reg <= 32'd0;
      count_reg  <= 32'd0;
    end else begin
      en_reg     <= en_next;
      mode_reg   <= mode_next;
      im_reg     <= im_next;
      sticky_reg <= sticky_next;
      preset_reg <= preset_next;
      count_reg  <= count_next;
    end
  end

  // Read mux
  always_comb begin
    dout = 32'd0;
    case (addr)
      2'd0:    dout = {28'd0, im_reg, mode_reg, en_reg};
      2'd1:    dout = preset_reg;
      2'd2:    dout = count_reg;
      default: dout = 32'd0;
    endcase
  end

  // Derived from registered state only; no path from din.
  assign irq = im_reg && ((state_reg == INT) || sticky_reg);

endmodule

// File: tb/tb_timer_dev.sv
// Testbench for timer_dev: a directed vector table, hand-written multi-cycle
// sequences and a randomized run, all checked against a cycle-level
// reference model of the timer's documented behaviour.
module tb_timer_dev;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  timer_dev dut (
    .clk  (clk),
    .rst  (rst),
    .addr (addr),
    .we   (we),
    .din  (din),
    .dout (dout),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int txn      = 0;

`ifdef TIMER_AUTORELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  // ---------------- reference model ----------------
  localparam int PH_IDLE = 0, PH_LOAD = 1, PH_COUNT = 2, PH_INT = 3;
  int        m_phase;
  bit        m_en, m_im, m_sticky;
  bit [1:0]  m_mode;
  bit [31:0] m_preset, m_count;

  task automatic m_reset();
    m_phase = PH_IDLE; m_en = 0; m_im = 0; m_sticky = 0;
    m_mode = 2'b00; m_preset = 0; m_count = 0;
  endtask

  function automatic bit [31:0] m_read(input bit [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_im, m_mode, m_en};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit m_irq();
    return m_im && ((m_phase == PH_INT) || m_sticky);
  endfunction

  // One clock edge: hardware behaviour first, then the bus write on top.
  task automatic m_step(input bit w, input bit [1:0] a, input bit [31:0] d);
    case (m_phase)
      PH_IDLE:  if (m_en) m_phase = PH_LOAD;
      PH_LOAD:  begin m_count = m_preset; m_phase = PH_COUNT; end
      PH_COUNT: begin
        if (!m_en)             m_phase = PH_IDLE;
        else if (m_count == 0) m_phase = PH_INT;
        else                   m_count = m_count - 1;
      end
      default: begin
        if (AUTO && m_mode == 2'b01) m_phase = PH_LOAD;
        else begin m_en = 0; m_sticky = 1; m_phase = PH_IDLE; end
      end
    endcase
    if (w && a == 2'd0) begin
      m_en = d[0]; m_mode = d[2:1]; m_im = d[3]; m_sticky = 0;
    end
    if (w && a == 2'd1) begin
      m_preset = d; m_sticky = 0;
    end
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called just after a falling edge; leaves at the next falling edge.
  task automatic cyc(input bit w, input bit [1:0] a, input bit [31:0] d);
    rst = 1'b0; we = w; din = d;
    if (w) begin
      addr = a; #1;
      check($sformatf("dout[a%0d]", a), dout, m_read(a));
    end else begin
      for (int i = 0; i < 4; i++) begin
        addr = i[1:0]; #1;
        check($sformatf("dout[a%0d]", i), dout, m_read(i[1:0]));
      end
      addr = a;
    end
    check("irq", {31'd0, irq}, {31'd0, m_irq()});
    $display("txn %0d we=%0d addr=%0d din=%h irq=%0d", txn, w, a, d, irq);
    txn++;
    @(posedge clk);
    m_step(w, a, d);
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rst_cyc(input bit w, input bit [1:0] a, input bit [31:0] d);
    rst = 1'b1; we = w; addr = a; din = d;
    $display("txn %0d rst=1 we=%0d addr=%0d din=%h", txn, w, a, d);
    txn++;
    @(posedge clk);
    m_reset();
    @(negedge clk);
    rst = 1'b0; we = 1'b0;
  endtask

  task automatic expect_reg(input string name, input bit [1:0] a, input logic [31:0] exp);
    we = 1'b0; addr = a; #1;
    check(name, dout, exp);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit        we;
    bit [1:0]  addr;
    bit [31:0] din;
    bit [31:0] exp_dout;
    bit        exp_irq;
  } vec_t;

  vec_t tbl[18];

  initial begin
    int pulses[$];
    bit [31:0] r;

    rst = 1'b1; we = 1'b0; addr = 2'd0; din = 32'd0;
    m_reset();

    // reset reads, then one-shot count from PRESET=5 with IM set
    tbl[0]  = '{0, 2'd0, 32'd0, 32'd0, 0};
    tbl[1]  = '{0, 2'd1, 32'd0, 32'd0, 0};
    tbl[2]  = '{0, 2'd2, 32'd0, 32'd0, 0};
    tbl[3]  = '{0, 2'd3, 32'd0, 32'd0, 0};
    tbl[4]  = '{1, 2'd1, 32'd5, 32'd0, 0};
    tbl[5]  = '{1, 2'd0, 32'h9, 32'd0, 0};
    tbl[6]  = '{0, 2'd2, 32'd0, 32'd0, 0};
    tbl[7]  = '{0, 2'd2, 32'd0, 32'd0, 0};
    tbl[8]  = '{0, 2'd2, 32'd0, 32'd5, 0};
    tbl[9]  = '{0, 2'd2, 32'd0, 32'd4, 0};
    tbl[10] = '{0, 2'd2, 32'd0, 32'd3, 0};
    tbl[11] = '{0, 2'd2, 32'd0, 32'd2, 0};
    tbl[12] = '{0, 2'd2, 32'd0, 32'd1, 0};
    tbl[13] = '{0, 2'd2, 32'd0, 32'd0, 0};
    tbl[14] = '{0, 2'd0, 32'd0, 32'h9, 1};
    tbl[15] = '{0, 2'd0, 32'd0, 32'h8, 1};
    tbl[16] = '{1, 2'd0, 32'd0, 32'h8, 1};
    tbl[17] = '{0, 2'd0, 32'd0, 32'd0, 0};

    @(negedge clk);
    rst_cyc(1, 2'd1, 32'hDEAD_BEEF);

    for (int i = 0; i < 18; i++) begin
      we = tbl[i].we; addr = tbl[i].addr; din = tbl[i].din; #1;
      check($sformatf("tbl%0d_dout", i), dout, tbl[i].exp_dout);
      check($sformatf("tbl%0d_irq", i), {31'd0, irq}, {31'd0, tbl[i].exp_irq});
      $display("txn %0d we=%0d addr=%0d din=%h dout=%h irq=%0d", txn, we, addr, din, dout, irq);
      txn++;
      @(posedge clk);
      m_step(tbl[i].we, tbl[i].addr, tbl[i].din);
      @(negedge clk);
      we = 1'b0;
    end

    // Disable at COUNT=6, frozen count, then re-enable reloads from PRESET
    rst_cyc(0, 2'd0, 32'd0);
    cyc(1, 2'd1, 32'd10);
    cyc(1, 2'd0, 32'h9);
    for (int i = 0; i < 6; i++) cyc(0, 2'd2, 32'd0);
    expect_reg("dis_at6", 2'd2, 32'd6);
    cyc(1, 2'd0, 32'h8);
    for (int i = 0; i < 4; i++) cyc(0, 2'd2, 32'd0);
    expect_reg("dis_frozen", 2'd2, 32'd5);
    check("dis_noirq", {31'd0, irq}, 32'd0);
    cyc(1, 2'd0, 32'h9);
    cyc(0, 2'd2, 32'd0);
    cyc(0, 2'd2, 32'd0);
    expect_reg("dis_reload", 2'd2, 32'd10);

    // PRESET=0 with IM=0: expiry clears EN, no irq; then IM set, flag already cleared
    rst_cyc(0, 2'd0, 32'd0);
    cyc(1, 2'd1, 32'd0);
    cyc(1, 2'd0, 32'h1);
    for (int i = 0; i < 6; i++) cyc(0, 2'd0, 32'd0);
    expect_reg("zero_en_clr", 2'd0, 32'd0);
    check("zero_noirq", {31'd0, irq}, 32'd0);
    cyc(1, 2'd0, 32'h8);
    expect_reg("zero_ctrl8", 2'd0, 32'h8);
    check("zero_noirq2", {31'd0, irq}, 32'd0);

    // Reset in the middle of a count, with a concurrent write
    rst_cyc(0, 2'd0, 32'd0);
    cyc(1, 2'd1, 32'd20);
    cyc(1, 2'd0, 32'h9);
    for (int i = 0; i < 15; i++) cyc(0, 2'd2, 32'd0);
    expect_reg("rst_at7", 2'd2, 32'd7);
    rst_cyc(1, 2'd1, 32'h0000_FFFF);
    expect_reg("rst_ctrl", 2'd0, 32'd0);
    expect_reg("rst_preset", 2'd1, 32'd0);
    expect_reg("rst_count", 2'd2, 32'd0);
    expect_reg("rst_resv", 2'd3, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    for (int i = 0; i < 3; i++) cyc(0, 2'd2, 32'd0);
    expect_reg("rst_idle", 2'd2, 32'd0);

    // MODE=01: periodic pulses when compiled in, else one-shot
    rst_cyc(0, 2'd0, 32'd0);
    cyc(1, 2'd1, 32'd3);
    cyc(1, 2'd0, 32'hB);
    for (int i = 0; i < 30; i++) begin
      if (irq) pulses.push_back(i);
      cyc(0, 2'd0, 32'd0);
    end
    if (AUTO) begin
      check("auto_npulses_ge4", {31'd0, pulses.size() >= 4}, 32'd1);
      for (int i = 1; i < pulses.size(); i++)
        check($sformatf("auto_period%0d", i), pulses[i] - pulses[i-1], 32'd6);
      expect_reg("auto_en_kept", 2'd0, 32'hB);
      expect_reg("auto_count_reload_range", 2'd2, (m_read(2'd2) <= 3) ? m_read(2'd2) : 32'hFFFF_FFFF);
    end else begin
      check("oneshot_irq_held", {31'd0, irq}, 32'd1);
      expect_reg("oneshot_ctrl", 2'd0, 32'hA);
      check("oneshot_first_irq", pulses.size() > 0 ? pulses[0] : -1, 32'd6);
    end

    // Randomized traffic against the model
    rst_cyc(0, 2'd0, 32'd0);
    for (int n = 0; n < 500; n++) begin
      r = $urandom;
      if ($urandom_range(0, 199) == 0) begin
        rst_cyc($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), r);
      end else begin
        case ($urandom_range(0, 11))
          0: begin
            r[0] = ($urandom_range(0, 3) != 0);
            cyc(1, 2'd0, r);
          end
          1:  cyc(1, 2'd1, 32'($urandom_range(0, 12)));
          2:  cyc(1, 2'd2, r);
          3:  cyc(1, 2'd3, r);
          default: cyc(0, 2'($urandom_range(0, 3)), r);
        endcase
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer_dev.md
TIMER_DEV -- requirements
Module: timer_dev

Interface
REQ-001 SHALL have port list: clk  input  1  system clock, all state updates on rising edge.
REQ-002 SHALL have port list: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port list: addr  input  2  word select (bus address bits [3:2]): 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved.
REQ-004 SHALL have port list: we  input  1  bus write strobe, single cycle.
REQ-005 SHALL have port list: din  input  32  bus write data.
REQ-006 SHALL have port list: dout  output  32  combinational read of register selected by addr; reserved reads 0.
REQ-007 SHALL have port list: irq  output  1  interrupt request, to one HWInt line of the exception coprocessor.

Function
REQ-008 CTRL SHALL hold bit0 EN, bits[2:1] MODE, bit3 IM; bits[31:4] SHALL read 0 and ignore writes.
REQ-009 PRESET SHALL be a 32-bit read/write register; COUNT SHALL be read-only (writes ignored).
REQ-010 FSM SHALL have states IDLE, LOAD, CNT, INT.
REQ-011 IDLE: if EN=1 SHALL go to LOAD next cycle; COUNT holds.
REQ-012 LOAD: COUNT SHALL take PRESET; SHALL go to CNT.
REQ-013 CNT: if EN=0 SHALL go to IDLE with COUNT frozen; else if COUNT=0 SHALL go to INT; else COUNT SHALL decrement by 1.
REQ-014 PRESET=N SHALL give exactly N decrement cycles; N=0 SHALL reach INT one cycle after LOAD.
REQ-015 INT, MODE=00: EN SHALL clear, sticky pending flag SHALL set, SHALL go to IDLE.
REQ-016 INT, MODE=01 (when compiled in): SHALL go to LOAD, EN unchanged, no sticky flag.
REQ-017 MODE values 10/11 SHALL behave as 00.
REQ-018 irq SHALL equal IM AND (state==INT OR sticky flag), registered-state derived, no combinational path from din.
REQ-019 Sticky flag SHALL clear on any bus write to CTRL or PRESET.
REQ-020 Bus write to CTRL in the same cycle FSM is in INT SHALL win over the hardware EN clear.
REQ-021 PRESET written while counting SHALL not affect COUNT until the next LOAD.
REQ-022 COUNT SHALL never wrap below 0.
REQ-023 Writes SHALL take effect at the next rising edge; dout SHALL reflect them the following cycle.

Reset
REQ-024 On rst=1 at a clock edge: CTRL=0, PRESET=0, COUNT=0, sticky flag=0, state=IDLE, irq=0.
REQ-025 rst SHALL override any concurrent bus write and any in-progress count.

Configuration
REQ-026 Macro TIMER_AUTORELOAD_EN defined: MODE=01 SHALL give periodic auto-reload per REQ-016, irq one-cycle pulse per period when IM=1.
REQ-027 TIMER_AUTORELOAD_EN undefined: MODE=01 SHALL behave exactly as MODE=00; MODE bits still read back as written.

Verification
REQ-028 Reset, then read addr 0/1/2/3 -> all 32'h0, irq=0.
REQ-029 Write PRESET=5, CTRL=32'h9 (EN, IM, mode0) -> COUNT 5,4,3,2,1,0 on successive cycles, irq rises at INT and stays high, CTRL reads 32'h8; write CTRL=0 -> irq low next cycle.
REQ-030 Autoreload build, PRESET=3, CTRL=32'hB -> irq one-cycle pulse every 6 cycles (LOAD+3 decrements+zero check+INT), COUNT reloads to 3, EN stays 1.
REQ-031 Count from PRESET=10, write CTRL=32'h8 (EN=0) at COUNT=6 -> state IDLE, COUNT frozen at 6 or 5 per write timing, no irq; rewrite EN=1 -> reload from PRESET=10.
REQ-032 PRESET=0, CTRL=32'h1 (IM=0) -> INT reached, EN clears, irq stays 0; then write CTRL=32'h8 -> irq stays 0 (flag cleared).
REQ-033 Assert rst during CNT with COUNT=7 -> next cycle all registers 0, state IDLE, irq 0.
